// File: rtl/cordic_rotation_unit.sv
// Iterative CORDIC engine in rotation mode.
// Rotates the vector (x_i, y_i) by the binary angle z_i. One quadrant pre-rotation cycle is
// followed by Iterations micro-rotations. Results are scaled by the CORDIC gain K ~ 1.6468
// (uncompensated).
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset; aborts any job in flight
//   start_i  request, sampled only in idle
//   x_i/y_i  signed operands (DataWidth), captured on an accepted start
//   z_i      signed binary angle (AngleWidth), -2^(W-1) = -pi
//   x_o/y_o  signed rotated vector (DataWidth+2), registered
//   z_o      residual angle after the last iteration
//   done_o   high in idle and in the single result cycle
module cordic_rotation_unit #(
  parameter int unsigned DataWidth      = 16,
  parameter int unsigned AngleWidth     = 16,
  parameter int unsigned IterationWidth = 4,
  parameter int unsigned Iterations     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DataWidth-1:0]  x_i,
  input  logic [DataWidth-1:0]  y_i,
  input  logic [AngleWidth-1:0] z_i,
  output logic [DataWidth+1:0]  x_o,
  output logic [DataWidth+1:0]  y_o,
  output logic [AngleWidth-1:0] z_o,
  output logic                  done_o
);

  localparam int unsigned XyWidth = DataWidth + 2;

  // +pi/2 and -pi/2 in the binary angle format.
  localparam logic signed [AngleWidth-1:0] PosQuarter = {2'b01, {(AngleWidth-2){1'b0}}};
  localparam logic signed [AngleWidth-1:0] NegQuarter = {2'b11, {(AngleWidth-2){1'b0}}};

  typedef enum logic [1:0] {StIdle, StPre, StCompute, StFinal} state_e;

  state_e                       state_q, state_d;
  logic [IterationWidth-1:0]    cnt_q, cnt_d;
  logic signed [XyWidth-1:0]    x_q, x_d, y_q, y_d;
  logic signed [AngleWidth-1:0] z_q, z_d;
  logic [XyWidth-1:0]           res_x_q, res_x_d, res_y_q, res_y_d;
  logic [AngleWidth-1:0]        res_z_q, res_z_d;

  logic                         last_iter;
  logic signed [XyWidth-1:0]    x_sh, y_sh;
  logic [15:0]                  atan16;
  logic [AngleWidth-1:0]        atan;

  assign last_iter = (cnt_q == IterationWidth'(Iterations - 1));
  assign x_sh      = x_q >>> cnt_q;
  assign y_sh      = y_q >>> cnt_q;

  // round(atan(2^-i) * 2^15 / pi), i.e. the table for a 16-bit angle.
  always_comb begin
    atan16 = 16'd0;
    case (32'(cnt_q))
      0:       atan16 = 16'd8192;
      1:       atan16 = 16'd4836;
      2:       atan16 = 16'd2555;
      3:       atan16 = 16'd1297;
      4:       atan16 = 16'd651;
      5:       atan16 = 16'd326;
      6:       atan16 = 16'd163;
      7:       atan16 = 16'd81;
      8:       atan16 = 16'd41;
      9:       atan16 = 16'd20;
      10:      atan16 = 16'd10;
      11:      atan16 = 16'd5;
      12:      atan16 = 16'd3;
      13:      atan16 = 16'd1;
      14:      atan16 = 16'd1;
      default: atan16 = 16'd0;
    endcase
  end

  // Other angle widths rescale the 16-bit table (precision is bounded by that table).
  if (AngleWidth >= 16) begin : g_atan_wide
    assign atan = AngleWidth'(atan16) << (AngleWidth - 16);
  end else begin : g_atan_narrow
    logic [16:0] atan_rnd;
    assign atan_rnd = 17'(atan16) + (17'd1 << (15 - AngleWidth));
    assign atan     = AngleWidth'(atan_rnd >> (16 - AngleWidth));
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_i) state_d = StPre;
      StPre:     state_d = StCompute;
      StCompute: if (last_iter) state_d = StFinal;
      StFinal:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    done_o = 1'b0;
    case (state_q)
      StIdle, StFinal: done_o = 1'b1;
      default:         done_o = 1'b0;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    res_z_d = res_z_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          x_d   = {{2{x_i[DataWidth-1]}}, x_i};
          y_d   = {{2{y_i[DataWidth-1]}}, y_i};
          z_d   = z_i;
          cnt_d = '0;
        end
      end
      StPre: begin
        // Bring the angle into [-pi/2, pi/2], inside the CORDIC convergence range.
        if (z_q > PosQuarter) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = z_q - PosQuarter;
        end else if (z_q < NegQuarter) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = z_q + PosQuarter;
        end
      end
      StCompute: begin
        if (!z_q[AngleWidth-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan;
        end
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          res_x_d = x_d;
          res_y_d = y_d;
          res_z_d = z_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      res_x_q <= '0;
      res_y_q <= '0;
      res_z_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
      res_z_q <= res_z_d;
    end
  end

  assign x_o = res_x_q;
  assign y_o = res_y_q;
  assign z_o = res_z_q;

endmodule

// File: tb/tb_cordic_rotation_unit.sv
module tb_cordic_rotation_unit;

  localparam int It = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start;
  logic [15:0] x_in, y_in, z_in;
  logic [17:0] x_out, y_out;
  logic [15:0] z_out;
  logic        done;

  cordic_rotation_unit #(
    .DataWidth     (16),
    .AngleWidth    (16),
    .IterationWidth(4),
    .Iterations    (It)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .start_i(start),
    .x_i    (x_in),
    .y_i    (y_in),
    .z_i    (z_in),
    .x_o    (x_out),
    .y_o    (y_out),
    .z_o    (z_out),
    .done_o (done)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int z;} res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   atan_tab[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

  function automatic int wrap16(int v);
    int t = v & 32'h0000FFFF;
    if (t >= 32768) t -= 65536;
    return t;
  endfunction

  function automatic int sx18(logic [17:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx16(logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Reference: the rotation rules evaluated with plain integer arithmetic.
  function automatic res_t model(int xi, int yi, int zi);
    res_t r;
    int x = xi;
    int y = yi;
    int z = wrap16(zi);
    int t;
    if (z > 16384) begin
      t = x; x = -y; y = t; z = z - 16384;
    end else if (z < -16384) begin
      t = x; x = y; y = -t; z = z + 16384;
    end
    for (int i = 0; i < It; i++) begin
      int dx = y >>> i;
      int dy = x >>> i;
      if (z >= 0) begin
        x = x - dx; y = y + dy; z = wrap16(z - atan_tab[i]);
      end else begin
        x = x + dx; y = y - dy; z = wrap16(z + atan_tab[i]);
      end
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_tol(string name, int act, int req, int tol);
    int diff = act - req;
    n_cmp++;
    if (diff > tol || diff < -tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d +-%0d", name, act, req, tol);
    end
  endtask

  // Monitor: pops the scoreboard on each completion, otherwise checks the results hold.
  initial begin
    bit   prev = 1'b1;
    res_t last = '{0, 0, 0};
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_ni !== 1'b1) begin
        prev = 1'b1;
        last = '{0, 0, 0};
      end else begin
        if (done && !prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got x=%0d, required no result", sx18(x_out));
          end else begin
            e = exp_q.pop_front();
            check("result_x", sx18(x_out), e.x);
            check("result_y", sx18(y_out), e.y);
            check("result_z", sx16(z_out), e.z);
          end
          last.x = sx18(x_out);
          last.y = sx18(y_out);
          last.z = sx16(z_out);
        end else begin
          check("hold_x", sx18(x_out), last.x);
          check("hold_y", sx18(y_out), last.y);
          check("hold_z", sx16(z_out), last.z);
        end
        prev = done;
      end
    end
  end

  // Issue one job from idle, return how many sampled cycles done stayed low.
  task automatic issue(int x, int y, int z, output int lowcnt);
    @(negedge clk);
    start = 1'b1;
    x_in  = x[15:0];
    y_in  = y[15:0];
    z_in  = z[15:0];
    exp_q.push_back(model(x, y, z));
    @(posedge clk);
    #1 start = 1'b0;
    lowcnt = 0;
    @(negedge clk);
    while (!done && lowcnt < 60) begin
      lowcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   lc;
    int   accepts;
    int   fall_at[$];
    bit   prevd;
    int   k;
    int   rx, ry, rz;

    rst_ni = 1'b0;
    start  = 1'b0;
    x_in   = '0;
    y_in   = '0;
    z_in   = '0;
    repeat (3) @(negedge clk);
    check("reset_done", int'(done), 1);
    check("reset_x", sx18(x_out), 0);
    check("reset_y", sx18(y_out), 0);
    check("reset_z", sx16(z_out), 0);
    rst_ni = 1'b1;

    // Zero angle: gain only.
    issue(10000, 0, 0, lc);
    check("latency_t1", lc, It + 1);
    check_tol("t1_x", sx18(x_out), 16468, 4);
    check_tol("t1_y", sx18(y_out), 0, 4);
    check_tol("t1_z", sx16(z_out), 0, 2);

    // +pi/2.
    issue(10000, 0, 16384, lc);
    check("latency_t2", lc, It + 1);
    check_tol("t2_x", sx18(x_out), 0, 4);
    check_tol("t2_y", sx18(y_out), 16468, 4);

    // -pi, exercises the negative pre-rotation.
    issue(10000, 0, -32768, lc);
    check_tol("t3_x", sx18(x_out), -16468, 4);
    check_tol("t3_y", sx18(y_out), 0, 4);

    // pi/4, then full-scale negative operands back to back.
    issue(10000, 0, 8192, lc);
    check_tol("t4_x", sx18(x_out), 11645, 4);
    check_tol("t4_y", sx18(y_out), 11645, 4);
    issue(-32767, -32767, 0, lc);
    check_tol("t4b_x", sx18(x_out), -53960, 8);
    check_tol("t4b_y", sx18(y_out), -53960, 8);

    // Random operands against the model.
    repeat (20) begin
      int rxv = int'($urandom_range(0, 65534)) - 32767;
      int ryv = int'($urandom_range(0, 65534)) - 32767;
      int rzv = int'($urandom_range(0, 65535));
      issue(rxv, ryv, rzv, lc);
      check("latency_rand", lc, It + 1);
    end

    // start held high: one acceptance per idle visit, 19 cycles apart.
    @(negedge clk);
    rx = 12345; ry = -2345; rz = 5000;
    start = 1'b1;
    x_in  = rx[15:0];
    y_in  = ry[15:0];
    z_in  = rz[15:0];
    prevd   = done;
    accepts = 0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (prevd && !done) begin
        accepts++;
        fall_at.push_back(i);
        exp_q.push_back(model(rx, ry, rz));
      end
      prevd = done;
    end
    start = 1'b0;
    check("held_accepts", accepts, 3);
    for (int i = 0; i < fall_at.size(); i++) check("held_accept_time", fall_at[i], 19 * i);
    k = 0;
    while (!done && k < 60) begin
      k++;
      @(negedge clk);
    end
    check("held_final_seen", int'(done), 1);

    // Reset while iteration 7 is in flight.
    @(negedge clk);
    start = 1'b1;
    x_in  = 16'd20000;
    y_in  = 16'd5000;
    z_in  = 16'hDCD8;  // -9000
    exp_q.push_back(model(20000, 5000, -9000));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_ni = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("abort_done", int'(done), 1);
    check("abort_x", sx18(x_out), 0);
    check("abort_y", sx18(y_out), 0);
    check("abort_z", sx16(z_out), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    issue(20000, 5000, -9000, lc);
    check("latency_after_abort", lc, It + 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
